// File: rtl/uart_tx_arbiter_if.sv
// Bundle linking four byte requesters, the arbiter and the shared UART transmitter.
// The master side (requesters + transmitter) drives requests and tx_busy; the slave side is the arbiter.
interface uart_tx_arbiter_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        busy;

    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_start, tx_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_start, tx_data, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Four-port byte arbiter feeding one shared UART transmitter, with optional idle gap between bytes.
// Define UART_ARB_FIXED_PRIO_EN for lowest-index-first selection; round-robin otherwise.
module uart_tx_arbiter #(
    parameter int GAP = 0,
    parameter int DW  = 8
) (
    input logic              clk,
    input logic              rstn,
    uart_tx_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_txStart;
    logic [DW-1:0]   r_txData;
    logic [1:0]      r_grantId;
    logic [1:0]      r_last;
    logic            r_busy;
    logic [7:0]      r_gapCnt;

    logic [1:0]      w_winner;
    logic            w_anyValid;
    logic [3:0]      w_ready;
    logic            w_accept;

    // Winner selection; the grant is gated by rstn so nothing is accepted while reset is held.
    always_comb begin
        w_winner   = 2'd0;
        w_anyValid = |bus.req_valid;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int k = 3; k >= 0; k--) begin
            if (bus.req_valid[k]) w_winner = 2'(k);
        end
`else
        for (int k = 4; k >= 1; k--) begin
            if (bus.req_valid[r_last + 2'(k)]) w_winner = r_last + 2'(k);
        end
`endif
        w_ready = 4'b0000;
        if (r_state == ST_IDLE && rstn && w_anyValid) w_ready[w_winner] = 1'b1;
    end

    assign w_accept = |w_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_txStart <= 1'b0;
            r_txData  <= '1;
            r_grantId <= 2'd0;
            r_last    <= 2'd3;
            r_busy    <= 1'b0;
            r_gapCnt  <= 8'd0;
        end else begin
            r_txStart <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_txData  <= bus.req_data[DW*w_winner +: DW];
                        r_grantId <= w_winner;
                        r_last    <= w_winner;
                        r_txStart <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (bus.tx_busy) r_state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        if (GAP > 0) begin
                            r_gapCnt <= 8'(GAP - 1);
                            r_state  <= ST_GAP;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gapCnt == 8'd0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt - 8'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.tx_start  = r_txStart;
    assign bus.tx_data   = r_txData;
    assign bus.grant_id  = r_grantId;
    assign bus.busy      = r_busy;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter GAP, default 0: idle clk cycles inserted after each completed byte, range 0..255.
REQ-002 SHALL have parameter DW, default 8: byte width, fixed at 8.
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  in  4  per-requester byte-valid; port i on bit i.
REQ-006 SHALL have port req_data  in  32  packed bytes; port i on [8i+7:8i].
REQ-007 SHALL have port req_ready  out  4  per-requester accept strobe.
REQ-008 SHALL have port tx_start  out  1  one-cycle start pulse to the shared UART transmitter.
REQ-009 SHALL have port tx_data  out  8  registered byte presented to the transmitter.
REQ-010 SHALL have port tx_busy  in  1  transmitter busy (high while frame on line).
REQ-011 SHALL have port grant_id  out  2  index of last accepted requester.
REQ-012 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
REQ-014 IDLE: if any req_valid, SHALL select one winner, assert req_ready[winner] combinationally that same cycle, latch req_data byte into tx_data and winner into grant_id, then go LAUNCH.
REQ-015 Transfer SHALL occur only on req_valid[i] & req_ready[i]; at most one req_ready bit high per cycle; req_ready all-zero outside IDLE.
REQ-016 LAUNCH: tx_start SHALL be 1 for exactly this one cycle; next state WAIT_BUSY.
REQ-017 WAIT_BUSY: SHALL remain until tx_busy=1, then go WAIT_DONE.
REQ-018 WAIT_DONE: SHALL remain until tx_busy=0, then go GAP if GAP>0, else IDLE.
REQ-019 GAP: 8-bit counter loaded with GAP-1 on entry, decremented each cycle; go IDLE when counter=0.
REQ-020 Latency: req_valid seen in IDLE at cycle t -> req_ready at t, tx_start at t+1.
REQ-021 tx_data SHALL be held constant from LAUNCH until next acceptance.
REQ-022 Requesters SHALL hold req_data stable while req_valid=1 and not yet accepted; arbiter SHALL not sample data outside the acceptance cycle.
REQ-023 Round-robin: pointer last holds last granted index; search order last+1, last+2, last+3, last (mod 4); pointer updates only on acceptance.
REQ-024 A requester dropping req_valid before acceptance SHALL lose its turn without side effect.
REQ-025 tx_busy already 1 on LAUNCH exit SHALL advance WAIT_BUSY->WAIT_DONE next cycle (no stall).
REQ-026 Unused FSM encodings SHALL return to IDLE next cycle.

Reset
REQ-027 rstn=0 at a clk edge SHALL force: state IDLE, tx_start 0, tx_data 8'hFF, req_ready 0, grant_id 0, busy 0, RR pointer 3 (port 0 first), GAP counter 0.
REQ-028 Reset mid-transfer SHALL abandon the byte in flight without retry; first cycle after release is IDLE.

Configuration
REQ-029 Macro UART_ARB_FIXED_PRIO_EN defined: winner = lowest-index valid requester; RR pointer still tracks grant but is unused for selection.
REQ-030 Macro UART_ARB_FIXED_PRIO_EN undefined (default): round-robin per REQ-023.

Verification
REQ-031 Single: req_valid=4'b0100, data2=8'h41, GAP=0 -> req_ready=4'b0100 same cycle, tx_start pulse next cycle, tx_data=8'h41, grant_id=2.
REQ-032 All valid continuously, bytes 8'h10..8'h13 -> tx_data order 10,11,12,13,10 (RR); with UART_ARB_FIXED_PRIO_EN -> 10,10,10,...
REQ-033 GAP=3, two queued bytes -> exactly 3 cycles busy=1 in GAP between tx_busy fall and next req_ready.
REQ-034 tx_busy held 0 after tx_start -> FSM stays WAIT_BUSY, no further req_ready, busy=1.
REQ-035 rstn=0 during WAIT_DONE -> next cycle all outputs at reset values, state IDLE; pending req re-granted starting from port 0.
